// File: rtl/cpu_pkg.sv
// Shared CPU types: bus opcodes, bus T-state encoding and the M-cycle length.
package cpu_pkg;

   typedef enum logic [2:0] {
      BUS_IDLE  = 3'd0,
      BUS_IF    = 3'd1,
      BUS_WRITE = 3'd2,
      BUS_READ  = 3'd3,
      BUS_IF_CB = 3'd4
   } bus_opcode_t;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_T4   = 3'd4
   } bus_state_t;

   localparam int unsigned T_PER_M = 4;

   // Encodings 5-7 fall through to "no strobe", i.e. they behave as an IDLE op.
   function automatic logic is_rd_op(input logic [2:0] op);
      return (op == BUS_READ) || (op == BUS_IF) || (op == BUS_IF_CB);
   endfunction

   function automatic logic is_fetch_op(input logic [2:0] op);
      return (op == BUS_IF) || (op == BUS_IF_CB);
   endfunction

endpackage

// File: rtl/cpu_bus_ctrl.sv
// CPU M-cycle bus sequencer: expands one request into T1-T4 with registered strobes.
// Optional wait states in T3 via `define CPU_BUS_WAIT_EN (adds mem_ready_i).
module cpu_bus_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 8,
   parameter logic [7:0]  IR_RST = 8'h00
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              op_valid_i,
   input  logic [2:0]        bus_op_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              op_ready_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              mem_rd_o,
   output logic              mem_wr_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
`ifdef CPU_BUS_WAIT_EN
   input  logic              mem_ready_i,
`endif
   output logic [DATA_W-1:0] rdata_o,
   output logic              rdata_valid_o,
   output logic [7:0]        ir_o,
   output logic              ir_load_o,
   output logic              cb_prefix_o,
   output logic              mcycle_end_o
);

   bus_state_t        r_state;
   bus_state_t        w_state_nxt;
   logic [2:0]        r_op;
   logic [2:0]        w_op_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic [7:0]        r_ir;
   logic              r_cb;
   logic              r_rd;
   logic              r_wr;
   logic              r_rdata_valid;
   logic              r_ir_load;
   logic              r_mcycle_end;
   logic              w_ready;
   logic              w_accept;
   logic              w_sample;
   logic              w_rd_nxt;
   logic              w_wr_nxt;

`ifdef CPU_BUS_WAIT_EN
   assign w_ready = mem_ready_i;
`else
   assign w_ready = 1'b1;
`endif

   always_comb begin
      w_state_nxt = r_state;
      op_ready_o  = (r_state == S_IDLE) || (r_state == S_T4);
      w_accept    = op_valid_i && op_ready_o;
      case (r_state)
         S_IDLE, S_T4: w_state_nxt = w_accept ? S_T1 : S_IDLE;
         S_T1:         w_state_nxt = S_T2;
         S_T2:         w_state_nxt = S_T3;
         S_T3:         w_state_nxt = w_ready ? S_T4 : S_T3;
         default:      w_state_nxt = S_IDLE;
      endcase
      w_op_nxt = w_accept ? bus_op_i : r_op;
      // Strobes are registered, so they are decoded from the state/op being entered.
      w_rd_nxt = is_rd_op(w_op_nxt) &&
                 ((w_state_nxt == S_T1) || (w_state_nxt == S_T2) || (w_state_nxt == S_T3));
      w_wr_nxt = (w_op_nxt == BUS_WRITE) &&
                 ((w_state_nxt == S_T2) || (w_state_nxt == S_T3));
      w_sample = (r_state == S_T3) && w_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_op          <= BUS_IDLE;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_rdata       <= '0;
         r_ir          <= IR_RST;
         r_cb          <= 1'b0;
         r_rd          <= 1'b0;
         r_wr          <= 1'b0;
         r_rdata_valid <= 1'b0;
         r_ir_load     <= 1'b0;
         r_mcycle_end  <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_op          <= w_op_nxt;
         r_rd          <= w_rd_nxt;
         r_wr          <= w_wr_nxt;
         r_rdata_valid <= w_sample && (r_op == BUS_READ);
         r_ir_load     <= w_sample && is_fetch_op(r_op);
         r_mcycle_end  <= w_sample;
         if (w_accept) begin
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
         end
         if (w_sample && (r_op == BUS_READ)) begin
            r_rdata <= mem_rdata_i;
         end
         if (w_sample && is_fetch_op(r_op)) begin
            r_ir <= mem_rdata_i[7:0];
            r_cb <= (r_op == BUS_IF_CB);
         end
      end
   end

   assign mem_addr_o    = r_addr;
   assign mem_wdata_o   = r_wdata;
   assign mem_rd_o      = r_rd;
   assign mem_wr_o      = r_wr;
   assign rdata_o       = r_rdata;
   assign rdata_valid_o = r_rdata_valid;
   assign ir_o          = r_ir;
   assign ir_load_o     = r_ir_load;
   assign cb_prefix_o   = r_cb;
   assign mcycle_end_o  = r_mcycle_end;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Scoreboard bench for cpu_bus_ctrl: stimulus pushes expected M-cycle results, monitor checks at each T4.
module tb_cpu_bus_ctrl;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        op_valid_i = 1'b0;
   logic [2:0]  bus_op_i = 3'd0;
   logic [15:0] addr_i = '0;
   logic [7:0]  wdata_i = '0;
   logic        op_ready_o;
   logic [15:0] mem_addr_o;
   logic [7:0]  mem_wdata_o;
   logic        mem_rd_o;
   logic        mem_wr_o;
   logic [7:0]  mem_rdata_i = '0;
`ifdef CPU_BUS_WAIT_EN
   logic        mem_ready_i = 1'b1;
`endif
   logic [7:0]  rdata_o;
   logic        rdata_valid_o;
   logic [7:0]  ir_o;
   logic        ir_load_o;
   logic        cb_prefix_o;
   logic        mcycle_end_o;

   cpu_bus_ctrl #(.ADDR_W(16), .DATA_W(8), .IR_RST(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .op_valid_i(op_valid_i), .bus_op_i(bus_op_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .op_ready_o(op_ready_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rd_o(mem_rd_o),
      .mem_wr_o(mem_wr_o), .mem_rdata_i(mem_rdata_i),
`ifdef CPU_BUS_WAIT_EN
      .mem_ready_i(mem_ready_i),
`endif
      .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .ir_o(ir_o),
      .ir_load_o(ir_load_o), .cb_prefix_o(cb_prefix_o), .mcycle_end_o(mcycle_end_o)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned cyc;
      logic [3:0]  rd_mask;
      logic [3:0]  wr_mask;
      logic [15:0] addr;
      logic        is_wr;
      logic [7:0]  wdata;
      logic        rv;
      logic        il;
      logic [7:0]  rdata;
      logic [7:0]  ir;
      logic        cb;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [7:0]  exp_rdata = 8'h00;
   logic [7:0]  exp_ir = 8'h00;
   logic        exp_cb = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Monitor: history of the last four T-states, checked when the DUT ends an M-cycle.
   logic [3:0]  rd_hist = '0;
   logic [3:0]  wr_hist = '0;
   logic [15:0] a_hist[4];
   always @(negedge clk) begin
      exp_t e;
      logic a_ok;
      rd_hist = {rd_hist[2:0], mem_rd_o};
      wr_hist = {wr_hist[2:0], mem_wr_o};
      a_hist[3] = a_hist[2]; a_hist[2] = a_hist[1]; a_hist[1] = a_hist[0]; a_hist[0] = mem_addr_o;
      if (rst_n) begin
         if (mcycle_end_o) begin
            if (sb.size() == 0) begin
               chk("unexpected_mcycle_end", 1, 0);
            end else begin
               e = sb.pop_front();
               a_ok = (a_hist[0] == e.addr) && (a_hist[1] == e.addr) &&
                      (a_hist[2] == e.addr) && (a_hist[3] == e.addr);
               chk("t4_cycle", cyc, e.cyc);
               chk("rd_strobe_T1..T4", rd_hist, e.rd_mask);
               chk("wr_strobe_T1..T4", wr_hist, e.wr_mask);
               chk("addr_held_T1..T4", a_ok, 1);
               if (e.is_wr) chk("wdata", mem_wdata_o, e.wdata);
               chk("rdata_valid", rdata_valid_o, e.rv);
               chk("ir_load", ir_load_o, e.il);
               chk("rdata", rdata_o, e.rdata);
               chk("ir", ir_o, e.ir);
               chk("cb_prefix", cb_prefix_o, e.cb);
            end
         end else if (rdata_valid_o || ir_load_o) begin
            chk("pulse_outside_T4", 1, 0);
         end
         if (sb.size() == 0 && (mem_rd_o || mem_wr_o)) chk("stray_strobe", 1, 0);
      end
   end

   task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [7:0] wd,
                        input logic [7:0] rd, input int unsigned waits,
                        output int unsigned waited);
      exp_t e;
      waited = 0;
      while (!op_ready_o && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!op_ready_o) begin
         chk("ready_timeout", 0, 1);
         return;
      end
      op_valid_i  = 1'b1;
      bus_op_i    = op;
      addr_i      = a;
      wdata_i     = wd;
      mem_rdata_i = rd;
      if (op == BUS_READ) exp_rdata = rd;
      if (op == BUS_IF || op == BUS_IF_CB) begin
         exp_ir = rd;
         exp_cb = (op == BUS_IF_CB);
      end
      e.cyc     = cyc + T_PER_M + waits;
      e.rd_mask = (op == BUS_READ || op == BUS_IF || op == BUS_IF_CB) ? 4'b1110 : 4'b0000;
      e.wr_mask = (op == BUS_WRITE) ? 4'b0110 : 4'b0000;
      e.addr    = a;
      e.is_wr   = (op == BUS_WRITE);
      e.wdata   = wd;
      e.rv      = (op == BUS_READ);
      e.il      = (op == BUS_IF || op == BUS_IF_CB);
      e.rdata   = exp_rdata;
      e.ir      = exp_ir;
      e.cb      = exp_cb;
      sb.push_back(e);
      @(negedge clk);
      op_valid_i = 1'b0;
      bus_op_i   = BUS_WRITE;
      addr_i     = 16'($urandom);
      wdata_i    = 8'($urandom);
`ifdef CPU_BUS_WAIT_EN
      if (waits > 0) begin
         repeat (2) @(negedge clk);
         mem_ready_i = 1'b0;
         mem_rdata_i = ~rd;
         repeat (waits) @(negedge clk);
         mem_ready_i = 1'b1;
         mem_rdata_i = rd;
      end
`endif
   endtask

   initial begin
      int unsigned w;
      repeat (3) @(negedge clk);
      chk("rst_rd", mem_rd_o, 0);
      chk("rst_wr", mem_wr_o, 0);
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_rdata", rdata_o, 0);
      chk("rst_ir", ir_o, 8'h00);
      chk("rst_cb", cb_prefix_o, 0);
      chk("rst_mcycle_end", mcycle_end_o, 0);
      chk("rst_ready", op_ready_o, 1);
      rst_n = 1'b1;
      @(negedge clk);

      issue(BUS_READ, 16'hC000, 8'h00, 8'hA5, 0, w);
      issue(BUS_IF, 16'h0100, 8'h00, 8'hCB, 0, w);
      issue(BUS_IF_CB, 16'h0101, 8'h00, 8'h37, 0, w);
      chk("b2b_gap", w, 3);
      issue(BUS_WRITE, 16'hFF80, 8'h5A, 8'hEE, 0, w);
      issue(BUS_IDLE, 16'h1234, 8'h00, 8'h77, 0, w);
      issue(3'd5, 16'h2222, 8'h11, 8'h99, 0, w);

      repeat (8) @(negedge clk);
      chk("idle_ready", op_ready_o, 1);
      chk("idle_no_end", mcycle_end_o, 0);

      issue(BUS_WRITE, 16'h8000, 8'hC3, 8'h00, 0, w);
      @(negedge clk);
      chk("wr_at_T2", mem_wr_o, 1);
      sb.delete();
      rst_n = 1'b0;
      #1;
      chk("abort_wr", mem_wr_o, 0);
      chk("abort_ir", ir_o, 8'h00);
      chk("abort_cb", cb_prefix_o, 0);
      chk("abort_ready", op_ready_o, 1);
      exp_rdata = 8'h00;
      exp_ir    = 8'h00;
      exp_cb    = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_ready", op_ready_o, 1);
      chk("post_rst_wr", mem_wr_o, 0);

      issue(BUS_READ, 16'h0042, 8'h00, 8'h81, 0, w);
`ifdef CPU_BUS_WAIT_EN
      issue(BUS_READ, 16'h4000, 8'h00, 8'h3C, 3, w);
`endif

      w = 0;
      while (sb.size() != 0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("drain", sb.size(), 0);
      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
